// File: rtl/imem_prog_loader.sv
// imem_prog_loader: streams a program into IMEM, runs the core, flags halt/timeout.
// Optional macro HALT_ECALL_EN: an ECALL fetched in RUN also halts the core.
module imem_prog_loader #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int CNT_W       = 16,
  parameter int MAX_CYCLES  = 1000,
  parameter int HALT_REPEAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_reset_n,
  output logic              core_en,
  input  logic [31:0]       core_pc,
  input  logic [DATA_W-1:0] core_instr,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int HW = $clog2(HALT_REPEAT + 1);

  localparam logic [DATA_W-1:0] BEQ_SELF =
    DATA_W'(32'h0000_0063);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MAX_CYCLES - 1);
  localparam logic [ADDR_W:0] LAST_IDX =
    (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [HW-1:0] HALT_LAST =
    HW'(HALT_REPEAT - 1);

  // S_FLUSH lets the final IMEM write land before the core fetches
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t          state;
  logic [31:0]     prev_pc;
  logic            prev_valid;
  logic [HW-1:0]   halt_cnt;

  logic accept;
  logic last_word;
  logic pc_hold;
  logic beq_hit;
  logic ecall_hit;
  logic halt_now;

  assign accept    = load_valid && load_ready;
  assign last_word = load_last || (words_loaded == LAST_IDX);
  assign pc_hold   = prev_valid && (core_pc == prev_pc);
  assign beq_hit   = (core_instr == BEQ_SELF) && pc_hold;

`ifdef HALT_ECALL_EN
  assign ecall_hit = (core_instr == DATA_W'(32'h0000_0073));
`else
  assign ecall_hit = 1'b0;
`endif

  assign halt_now = (beq_hit && (halt_cnt == HALT_LAST))
                  || ecall_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      load_ready   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset_n <= 1'b0;
      core_en      <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      words_loaded <= '0;
      prev_pc      <= '0;
      prev_valid   <= 1'b0;
      halt_cnt     <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          state      <= S_LOAD;
          load_ready <= 1'b1;
        end
        S_LOAD: begin
          if (accept) begin
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= load_data;
            words_loaded <= words_loaded + (ADDR_W + 1)'(1);
            if (last_word) begin
              load_ready <= 1'b0;
              state      <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          state        <= S_RUN;
          core_reset_n <= 1'b1;
          core_en      <= 1'b1;
          prev_valid   <= 1'b0;
          halt_cnt     <= '0;
        end
        S_RUN: begin
          prev_pc    <= core_pc;
          prev_valid <= 1'b1;
          halt_cnt   <= beq_hit ? halt_cnt + HW'(1) : '0;
          if (halt_now) begin
            state   <= S_DONE;
            done    <= 1'b1;
            core_en <= 1'b0;
          end else if (cycle_count == CNT_LAST) begin
            state   <= S_TIMEOUT;
            timeout <= 1'b1;
            core_en <= 1'b0;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        S_DONE, S_TIMEOUT: begin
          if (clear) begin
            state        <= S_IDLE;
            done         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
            words_loaded <= '0;
            core_reset_n <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
